// File: rtl/riscv_fetch_unit_pkg.sv
//==============================================================================
// Module   : riscv_fetch_unit_pkg
// Brief    : Shared CPU constants (NOP, base opcodes) and fetch queue entry type.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package riscv_fetch_unit_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] c_instr_nop = 32'h0000_0013;

    localparam logic [6:0] c_opc_lw     = 7'b0000011;
    localparam logic [6:0] c_opc_sw     = 7'b0100011;
    localparam logic [6:0] c_opc_beq    = 7'b1100011;
    localparam logic [6:0] c_opc_alu    = 7'b0110011;
    localparam logic [6:0] c_opc_alu_im = 7'b0010011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_fetch_unit_queue.sv
//==============================================================================
// Module   : fetch_queue
// Brief    : Prefetch FIFO of {pc, instr} entries with push/pop/flush and count.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_queue
    import riscv_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_instr,
    input  logic                     pop,
    input  logic                     flush,
    output logic [31:0]              head_pc,
    output logic [31:0]              head_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [CW-1:0]  r_count;
    logic           w_pop;
    logic           w_push;

    // A flush wins over everything; a pop frees a slot for a same-cycle push.
    assign w_pop  = pop && (r_count != '0) && !flush;
    assign w_push = push && !flush && ((r_count != c_full) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr].pc    <= push_pc;
            r_mem[r_wr].instr <= push_instr;
        end
    end

    assign head_pc    = r_mem[r_rd].pc;
    assign head_instr = r_mem[r_rd].instr;
    assign count      = r_count;

endmodule

`default_nettype wire

// File: rtl/riscv_fetch_unit.sv
//==============================================================================
// Module   : riscv_fetch_unit
// Brief    : Instruction fetch with prefetch queue, redirect flush and
//            stale-response discard. FETCH_PERF_EN adds perf counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module riscv_fetch_unit
    import riscv_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    input  logic        ifid_ready,
    output logic [31:0] ifid_instr,
`ifdef FETCH_PERF_EN
    output logic [31:0] ifid_pc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`else
    output logic [31:0] ifid_pc
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] c_depth = (CW+1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_inflight;
    logic          w_req_fire;
    logic          w_rsp_keep;
    logic          w_pop;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_head_instr;

    // Outstanding requests are counted against the queue so every response lands.
    assign w_inflight     = {1'b0, w_count} + {1'b0, r_outst};
    assign imem_req_valid = rst_n && !redirect_valid && (w_inflight < c_depth);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_keep     = imem_rsp_valid && !redirect_valid && (r_discard == '0);
    assign w_pop          = ifid_valid && ifid_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= align_pc(RESET_PC);
            r_rsp_pc  <= align_pc(RESET_PC);
            r_outst   <= '0;
            r_discard <= '0;
        end else begin
            r_outst <= r_outst + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                r_pc      <= align_pc(redirect_pc);
                r_rsp_pc  <= align_pc(redirect_pc);
                // A response in this very cycle is already dropped.
                r_discard <= r_outst - CW'(imem_rsp_valid);
            end else begin
                if (w_req_fire)
                    r_pc <= r_pc + 32'd4;
                if (w_rsp_keep)
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                if (imem_rsp_valid && (r_discard != '0))
                    r_discard <= r_discard - CW'(1);
            end
        end
    end

    fetch_queue #(
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_rsp_keep),
        .push_pc    (r_rsp_pc),
        .push_instr (imem_rsp_data),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .head_pc    (w_head_pc),
        .head_instr (w_head_instr),
        .count      (w_count)
    );

    assign ifid_valid = (w_count != '0);
    assign ifid_instr = ifid_valid ? w_head_instr : c_instr_nop;
    assign ifid_pc    = ifid_valid ? w_head_pc : 32'h0;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_rsp_keep)
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if (ifid_ready && !ifid_valid)
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_fetch_unit.sv
//==============================================================================
// Module   : tb_riscv_fetch_unit
// Brief    : Directed self-checking bench for riscv_fetch_unit with a
//            variable-latency in-order memory model. FETCH_PERF_EN aware.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_riscv_fetch_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_nop      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acc   = 0;
    int          n_pop   = 0;
    logic [31:0] exp_pc;
    int          lat = 1;

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .RESET_PC       (c_reset_pc),
        .DEPTH          (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_ready     (ifid_ready),
        .ifid_instr     (ifid_instr),
`ifdef FETCH_PERF_EN
        .ifid_pc        (ifid_pc),
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`else
        .ifid_pc        (ifid_pc)
`endif
    );

    function automatic logic [31:0] mk(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // In-order memory, response 'lat' cycles after acceptance, reset with the DUT.
    logic [3:0]  r_pv;
    logic [31:0] r_pa [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
        end else begin
            r_pv    <= {r_pv[2:0], imem_req_valid && imem_req_ready};
            r_pa[0] <= imem_req_addr;
            r_pa[1] <= r_pa[0];
            r_pa[2] <= r_pa[1];
            r_pa[3] <= r_pa[2];
        end
    end

    assign imem_rsp_valid = r_pv[lat-1];
    assign imem_rsp_data  = mk(r_pa[lat-1]);

    always @(posedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) n_acc <= n_acc + 1;
        if (rst_n && ifid_valid && ifid_ready)         n_pop <= n_pop + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample at the falling edge; every consumed instruction is scoreboarded.
    task automatic samp();
        @(negedge clk);
        if (rst_n && ifid_valid && ifid_ready) begin
            chk("pop_pc", ifid_pc, exp_pc);
            chk("pop_instr", ifid_instr, mk(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        samp();
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_pop;
        int acc_mid;
        bit seen;

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_pc         = c_reset_pc;
        repeat (3) adv();

        samp();
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_ifid_instr", ifid_instr, c_nop);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        adv();

        // Streaming from reset with 1-cycle memory
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            samp();
            chk("stream_addr", imem_req_addr, c_reset_pc + 32'(4 * c));
            chk("stream_req_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("stream_ifid_valid", {31'd0, ifid_valid}, (c >= 2) ? 32'd1 : 32'd0);
            adv();
        end

        // Decode stall: exactly DEPTH requests in queue/flight, then drain
        ifid_ready = 1'b0;
        repeat (5) tick();
        acc_mid = n_acc;
        repeat (15) tick();
        samp();
        chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("stall_inflight", 32'(n_acc - n_pop), 32'd4);
        chk("stall_no_new_req", 32'(n_acc), 32'(acc_mid));
        chk("stall_ifid_valid", {31'd0, ifid_valid}, 32'd1);
        adv();
        ifid_ready = 1'b1;
        base_pop   = n_pop;
        repeat (12) tick();
        chk("drain_pops", 32'(n_pop - base_pop), 32'd12);

        // Redirect with three responses outstanding (3-cycle memory)
        imem_req_ready = 1'b0;
        repeat (6) tick();
        lat            = 3;
        imem_req_ready = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        exp_pc         = 32'h0000_0100;
        samp();
        chk("redir_req_blocked", {31'd0, imem_req_valid}, 32'd0);
        adv();
        redirect_valid = 1'b0;
        samp();
        chk("redir_next_addr", imem_req_addr, 32'h0000_0100);
        chk("redir_next_valid", {31'd0, imem_req_valid}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            adv();
            samp();
            if (ifid_valid) begin
                seen = 1'b1;
                chk("redir_first_pc", ifid_pc, 32'h0000_0100);
            end
        end
        chk("redir_wait", {31'd0, seen}, 32'd1);
        adv();
        repeat (4) tick();

        // Back-pressure on the request port across the address wrap
        imem_req_ready = 1'b0;
        repeat (6) tick();
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        exp_pc         = 32'hFFFF_FFFC;
        adv();
        redirect_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            samp();
            chk("hold_addr", imem_req_addr, 32'hFFFF_FFFC);
            chk("hold_valid", {31'd0, imem_req_valid}, 32'd1);
            adv();
        end
        imem_req_ready = 1'b1;
        adv();
        samp();
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);
        adv();
        repeat (6) tick();

        // Mid-stream asynchronous reset
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("mid_rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
        chk("mid_rst_ifid_instr", ifid_instr, c_nop);
        chk("mid_rst_ifid_pc", ifid_pc, 32'h0);
        adv();
        adv();
        rst_n  = 1'b1;
        exp_pc = c_reset_pc;
        for (int c = 0; c <= 12; c++) begin
            imem_req_ready = (c != 3);
            samp();
            if (c == 0) chk("restart_addr", imem_req_addr, c_reset_pc);
`ifdef FETCH_PERF_EN
            if (c == 12) begin
                chk("perf_fetched", perf_fetched, 32'd10);
                chk("perf_bubbles", perf_bubbles, 32'd3);
            end
`endif
            adv();
        end
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
